// File: rtl/uw_wez_sink_if.sv
// Handshake bundle between the uw stage, the wez sink FIFO and its consumer.
// UW_SINK_XCHK_EN selects a 4-state in_data so X/Z words can reach the sink.
interface uw_wez_sink_if #(
   parameter int unsigned W = 12
);
`ifdef UW_SINK_XCHK_EN
   logic [W-1:0] in_data;
`else
   bit   [W-1:0] in_data;
`endif
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   // master: producer and consumer side; slave: the sink FIFO
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/uw_wez_sink.sv
// First-word fall-through sink FIFO for the uw wez bus with a toggle-activity counter.
// Define UW_SINK_XCHK_EN to drop (and count) handshaked words carrying X/Z bits.
module uw_wez_sink #(
   parameter int unsigned W     = 12,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNTW  = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   uw_wez_sink_if.slave    bus,
   output logic [CNTW-1:0] chg_cnt,
   output logic [AW:0]     level,
   output logic [CNTW-1:0] xdrop_cnt
);

   logic [W-1:0]    mem [DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] chg_cnt_q, chg_cnt_d;
   logic [W-1:0]    prev_word_q, prev_word_d;
   logic            have_prev_q, have_prev_d;
   logic [W-1:0]    last_q, last_d;
   logic            full, empty;
   logic            accept, pop, xword, wr_en;
   logic [W-1:0]    head;

   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign head  = mem[rd_ptr_q[AW-1:0]];

   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.out_data  = empty ? last_q : head;
   assign level         = wr_ptr_q - rd_ptr_q;
   assign chg_cnt       = chg_cnt_q;

   assign accept = bus.in_valid && !full;
   assign pop    = !empty && bus.out_ready;

`ifdef UW_SINK_XCHK_EN
   logic [CNTW-1:0] xdrop_cnt_q, xdrop_cnt_d;

   // an X/Z word is still handshaked (in_ready applies) but never stored
   assign xword     = (^bus.in_data === 1'bx);
   assign xdrop_cnt = xdrop_cnt_q;

   always_comb begin
      xdrop_cnt_d = xdrop_cnt_q;
      if (accept && xword && (xdrop_cnt_q != '1)) begin
         xdrop_cnt_d = xdrop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xdrop_cnt_q <= '0;
      end else begin
         xdrop_cnt_q <= xdrop_cnt_d;
      end
   end
`else
   assign xword     = 1'b0;
   assign xdrop_cnt = '0;
`endif

   assign wr_en = accept && !xword;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      chg_cnt_d   = chg_cnt_q;
      prev_word_d = prev_word_q;
      have_prev_d = have_prev_q;
      last_d      = last_q;
      if (wr_en) begin
         wr_ptr_d    = wr_ptr_q + 1'b1;
         prev_word_d = bus.in_data;
         have_prev_d = 1'b1;
         if (have_prev_q && (bus.in_data != prev_word_q) && (chg_cnt_q != '1)) begin
            chg_cnt_d = chg_cnt_q + 1'b1;
         end
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // keep a copy of the visible head so out_data holds once the FIFO empties
      if (!empty) begin
         last_d = head;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         chg_cnt_q   <= '0;
         prev_word_q <= '0;
         have_prev_q <= 1'b0;
         last_q      <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         chg_cnt_q   <= chg_cnt_d;
         prev_word_q <= prev_word_d;
         have_prev_q <= have_prev_d;
         last_q      <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem[wr_ptr_q[AW-1:0]] <= bus.in_data;
      end
   end

endmodule
